// File: rtl/comm_pkg.sv
// Shared definitions for the UART command frame decoder.
// Holds frame type codes, response codes, the rx FSM state encoding
// and a bit-to-byte count helper used to size multi-byte fields.
package comm_pkg;

  localparam logic [7:0] TYPE_SYS   = 8'h01;
  localparam logic [7:0] TYPE_STEP  = 8'h02;
  localparam logic [7:0] TYPE_RANGE = 8'h03;
  localparam logic [7:0] TYPE_BASE  = 8'h04;
  localparam logic [7:0] TYPE_WRITE = 8'h05;

  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TYPE,
    ST_PAYLOAD,
    ST_CHECK
  } rx_state_t;

  // Number of whole bytes needed to carry a field of the given bit width.
  function automatic int byte_count(input int bits);
    return (bits + 7) / 8;
  endfunction

endpackage

// File: rtl/comm_frame_decoder_if.sv
// Byte-stream and RAM-write bus between the UART/RAM side and the decoder.
// Signals: rx_valid/rx_data (received byte strobe), tx_busy/tx_data/send_data
// (response byte handshake), wr_enable/wr_addr/wr_data (waveform RAM write).
interface comm_frame_decoder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  tx_busy;
  logic [7:0]            tx_data;
  logic                  send_data;
  logic                  wr_enable;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  // Decoder side.
  modport slave (
    input  rx_valid, rx_data, tx_busy,
    output tx_data, send_data, wr_enable, wr_addr, wr_data
  );

  // UART / RAM side.
  modport master (
    output rx_valid, rx_data, tx_busy,
    input  tx_data, send_data, wr_enable, wr_addr, wr_data
  );
endinterface

// File: rtl/comm_tx_responder.sv
// One-byte pending response register feeding the UART transmitter.
// Ports: load/load_byte queue a response; tx_busy holds it back;
// tx_data/send_data present the byte with a one-cycle strobe.
module comm_tx_responder (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_byte,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       send_data
);

  logic       pending;
  logic [7:0] pend_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      pending   <= 1'b0;
      pend_byte <= 8'h00;
      tx_data   <= 8'h00;
      send_data <= 1'b0;
    end else begin
      send_data <= 1'b0;
      if (pending && !tx_busy) begin
        send_data <= 1'b1;
        tx_data   <= pend_byte;
        pending   <= 1'b0;
      end
      // A load in the same cycle as a send wins: the newer byte stays pending.
      if (load) begin
        pending   <= 1'b1;
        pend_byte <= load_byte;
      end
    end
  end

endmodule

// File: rtl/comm_frame_decoder.sv
// Decodes LEN/TYPE/payload/CHK frames from the UART byte stream.
// Ports: clk/reset, bus (rx bytes, tx response, RAM writes), committed
// step/range/base_addr, and sys_reset/frame_err one-cycle pulses.
module comm_frame_decoder
  import comm_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 12,
  parameter int CFG_WIDTH      = 12,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  comm_frame_decoder_if.slave   bus,
  output logic [CFG_WIDTH-1:0]  step,
  output logic [CFG_WIDTH-1:0]  range,
  output logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  sys_reset,
  output logic                  frame_err
);

  localparam int DATA_BYTES = byte_count(DATA_WIDTH);
  localparam int CFG_BYTES  = byte_count(CFG_WIDTH);
  localparam int ADDR_BYTES = byte_count(ADDR_WIDTH);
  localparam int SHW        = (CFG_WIDTH > ADDR_WIDTH) ? CFG_WIDTH : ADDR_WIDTH;
  localparam int BIDX_W     = $clog2(DATA_BYTES + 1);
  localparam int GAP_W      = $clog2(TIMEOUT_CYCLES);

  rx_state_t             state;
  logic [7:0]            len;
  logic [7:0]            typ;
  logic [7:0]            cnt;
  logic [7:0]            chk;
  logic [SHW-1:0]        shadow;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] acc_next;
  logic [BIDX_W-1:0]     bidx;
  logic [ADDR_WIDTH-1:0] sidx;
  logic [GAP_W-1:0]      gap;
  logic                  len_ok;
  logic                  frame_ok;
  logic                  rsp_load;

  // Shifting MSB first and truncating keeps only the low bits of each field.
  assign acc_next = DATA_WIDTH'({acc, bus.rx_data});

  always_comb begin
    len_ok = 1'b0;
    case (typ)
      TYPE_SYS:              len_ok = (len == 8'd1);
      TYPE_STEP, TYPE_RANGE: len_ok = (len == 8'(CFG_BYTES));
      TYPE_BASE:             len_ok = (len == 8'(ADDR_BYTES));
      TYPE_WRITE:            len_ok = ((int'(len) % DATA_BYTES) == 0);
      default:               len_ok = 1'b0;
    endcase
  end

  assign frame_ok = len_ok && (bus.rx_data == chk);
  // Response is queued on the CHK byte itself so it is pending one cycle later.
  assign rsp_load = bus.rx_valid && (state == ST_CHECK);

  comm_tx_responder u_tx (
    .clk       (clk),
    .reset     (reset),
    .load      (rsp_load),
    .load_byte (frame_ok ? RSP_ACK : RSP_NAK),
    .tx_busy   (bus.tx_busy),
    .tx_data   (bus.tx_data),
    .send_data (bus.send_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      len           <= 8'h00;
      typ           <= 8'h00;
      cnt           <= 8'h00;
      chk           <= 8'h00;
      shadow        <= '0;
      acc           <= '0;
      bidx          <= '0;
      sidx          <= '0;
      gap           <= '0;
      bus.wr_enable <= 1'b0;
      bus.wr_addr   <= '0;
      bus.wr_data   <= '0;
      step          <= CFG_WIDTH'(1);
      range         <= '1;
      base_addr     <= '0;
      sys_reset     <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      bus.wr_enable <= 1'b0;
      sys_reset     <= 1'b0;
      frame_err     <= 1'b0;
      if (bus.rx_valid) begin
        // A byte arriving on the expiry cycle wins over the timeout.
        gap <= '0;
        case (state)
          ST_IDLE: begin
            len   <= bus.rx_data;
            chk   <= bus.rx_data;
            cnt   <= 8'h00;
            state <= ST_TYPE;
          end
          ST_TYPE: begin
            typ    <= bus.rx_data;
            chk    <= chk ^ bus.rx_data;
            shadow <= '0;
            acc    <= '0;
            bidx   <= '0;
            sidx   <= '0;
            state  <= (len == 8'h00) ? ST_CHECK : ST_PAYLOAD;
          end
          ST_PAYLOAD: begin
            chk    <= chk ^ bus.rx_data;
            shadow <= SHW'({shadow, bus.rx_data});
            cnt    <= cnt + 8'd1;
            if (typ == TYPE_WRITE) begin
              acc <= acc_next;
              if (bidx == BIDX_W'(DATA_BYTES - 1)) begin
                // RAM writes are streamed as they complete; no rollback later.
                bidx          <= '0;
                sidx          <= sidx + 1'b1;
                bus.wr_enable <= 1'b1;
                bus.wr_addr   <= base_addr + sidx;
                bus.wr_data   <= acc_next;
              end else begin
                bidx <= bidx + 1'b1;
              end
            end
            if (cnt == len - 8'd1) state <= ST_CHECK;
          end
          ST_CHECK: begin
            state <= ST_IDLE;
            if (frame_ok) begin
              case (typ)
                TYPE_SYS:   sys_reset <= shadow[0];
                TYPE_STEP:  step      <= shadow[CFG_WIDTH-1:0];
                TYPE_RANGE: range     <= shadow[CFG_WIDTH-1:0];
                TYPE_BASE:  base_addr <= shadow[ADDR_WIDTH-1:0];
                default: ;
              endcase
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE) begin
        if (gap == GAP_W'(TIMEOUT_CYCLES - 1)) begin
          gap       <= '0;
          state     <= ST_IDLE;
          frame_err <= 1'b1;
        end else begin
          gap <= gap + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_comm_frame_decoder.sv
// Self-checking bench for comm_frame_decoder: reset values, a fixed vector
// table, hand sequences for timing/wrap/timeout/reset, and random frames
// compared against a frame-level reference model.
module tb_comm_frame_decoder;
  import comm_pkg::*;

  localparam int DW = 16;
  localparam int AW = 12;
  localparam int CW = 12;
  localparam int TO = 40;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [CW-1:0] step, range;
  logic [AW-1:0] base_addr;
  logic sys_reset, frame_err;

  comm_frame_decoder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  comm_frame_decoder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CFG_WIDTH(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .step(step), .range(range),
    .base_addr(base_addr), .sys_reset(sys_reset), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Event recorders (single writer: this block).
  logic [7:0] tx_q[$];
  int wr_a_q[$];
  int wr_d_q[$];
  int err_cnt = 0;
  int sysr_cnt = 0;
  always @(negedge clk) begin
    if (bus.send_data) tx_q.push_back(bus.tx_data);
    if (bus.wr_enable) begin
      wr_a_q.push_back(int'(bus.wr_addr));
      wr_d_q.push_back(int'(bus.wr_data));
    end
    if (frame_err) err_cnt++;
    if (sys_reset) sysr_cnt++;
  end

  // Reference model committed state.
  int m_step, m_range, m_base;
  int t0, w0, e0, s0;
  logic [7:0] frm[$];

  typedef struct {
    logic [7:0]  len, typ, p0, p1;
    bit          corrupt;
    logic [7:0]  rsp;
    int          err;
    logic [11:0] st, rg, ba;
  } vec_t;
  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic finish_frame(input bit corrupt);
    logic [7:0] x;
    x = 8'h00;
    foreach (frm[i]) x ^= frm[i];
    frm.push_back(corrupt ? (x ^ 8'h5A) : x);
  endtask

  task automatic send_frm(input int max_gap);
    for (int i = 0; i < frm.size(); i++) begin
      send_byte(frm[i]);
      if (i < frm.size() - 1) repeat ($urandom_range(0, max_gap)) tick();
    end
  endtask

  task automatic snap();
    t0 = tx_q.size();
    w0 = wr_a_q.size();
    e0 = err_cnt;
    s0 = sysr_cnt;
  endtask

  // Frame-level model: legality from type rules, checksum from XOR of all
  // bytes, writes as big-endian byte pairs at base + index mod 2^AW.
  task automatic model_check(input string tag);
    int len, typ, n, nw, val;
    logic [7:0] x;
    bit legal, ok, sr;
    len = int'(frm[0]);
    typ = int'(frm[1]);
    n = frm.size();
    x = 8'h00;
    for (int i = 0; i < n - 1; i++) x ^= frm[i];
    case (typ)
      1:       legal = (len == 1);
      2, 3, 4: legal = (len == 2);
      5:       legal = (len % 2 == 0);
      default: legal = 1'b0;
    endcase
    ok = legal && (x == frm[n-1]);
    nw = (typ == 5) ? len / 2 : 0;
    check({tag, "_nwr"}, wr_a_q.size() - w0, nw);
    for (int i = 0; i < nw; i++) begin
      if (w0 + i < wr_a_q.size()) begin
        check({tag, "_wa"}, wr_a_q[w0+i], (m_base + i) % 4096);
        check({tag, "_wd"}, wr_d_q[w0+i], int'(frm[2+2*i]) * 256 + int'(frm[3+2*i]));
      end
    end
    val = (len >= 2) ? ((int'(frm[2]) * 256 + int'(frm[3])) % 4096) : 0;
    sr = 1'b0;
    if (ok && typ == 1) sr = frm[2][0];
    if (ok) begin
      case (typ)
        2: m_step  = val;
        3: m_range = val;
        4: m_base  = val;
        default: ;
      endcase
    end
    check({tag, "_nrsp"}, tx_q.size() - t0, 1);
    if (tx_q.size() > t0) check({tag, "_rsp"}, tx_q[t0], ok ? 8'h06 : 8'h15);
    check({tag, "_err"}, err_cnt - e0, ok ? 0 : 1);
    check({tag, "_sysr"}, sysr_cnt - s0, sr ? 1 : 0);
    check({tag, "_step"}, step, m_step);
    check({tag, "_range"}, range, m_range);
    check({tag, "_base"}, base_addr, m_base);
  endtask

  initial begin
    int len, typ, k;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_busy  = 1'b0;

    tbl[0] = '{8'h02, 8'h02, 8'h00, 8'h05, 1'b0, 8'h06, 0, 12'h005, 12'hFFF, 12'h000};
    tbl[1] = '{8'h02, 8'h02, 8'h00, 8'h07, 1'b1, 8'h15, 1, 12'h005, 12'hFFF, 12'h000};
    tbl[2] = '{8'h02, 8'h03, 8'h0A, 8'hBC, 1'b0, 8'h06, 0, 12'h005, 12'hABC, 12'h000};
    tbl[3] = '{8'h02, 8'h03, 8'hFF, 8'h34, 1'b0, 8'h06, 0, 12'h005, 12'hF34, 12'h000};
    tbl[4] = '{8'h01, 8'h02, 8'h09, 8'h00, 1'b0, 8'h15, 1, 12'h005, 12'hF34, 12'h000};
    tbl[5] = '{8'h02, 8'h04, 8'h0F, 8'hFE, 1'b0, 8'h06, 0, 12'h005, 12'hF34, 12'hFFE};
    tbl[6] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h15, 1, 12'h005, 12'hF34, 12'hFFE};
    tbl[7] = '{8'h00, 8'h05, 8'h00, 8'h00, 1'b0, 8'h06, 0, 12'h005, 12'hF34, 12'hFFE};
    tbl[8] = '{8'h02, 8'h07, 8'h11, 8'h22, 1'b0, 8'h15, 1, 12'h005, 12'hF34, 12'hFFE};

    // Reset values.
    repeat (3) tick();
    check("rst_step", step, 12'h001);
    check("rst_range", range, 12'hFFF);
    check("rst_base", base_addr, 12'h000);
    check("rst_tx", {bus.send_data, bus.tx_data}, 9'h000);
    check("rst_wr", {bus.wr_enable, bus.wr_addr, bus.wr_data}, 29'h0);
    check("rst_pulses", {sys_reset, frame_err}, 2'b00);
    reset = 1'b0;
    tick();

    // Commit timing and tx_busy hold-off.
    bus.tx_busy = 1'b1;
    snap();
    send_byte(8'h02); send_byte(8'h02); send_byte(8'h00); send_byte(8'h09);
    check("tim_step_before", step, 12'h001);
    send_byte(8'h09);
    check("tim_step_n1", step, 12'h009);
    check("tim_err_n1", frame_err, 1'b0);
    repeat (5) tick();
    check("tim_busy_hold", tx_q.size() - t0, 0);
    bus.tx_busy = 1'b0;
    repeat (3) tick();
    check("tim_nrsp", tx_q.size() - t0, 1);
    if (tx_q.size() > t0) check("tim_rsp", tx_q[t0], 8'h06);

    // Vector table.
    for (int i = 0; i < 9; i++) begin
      snap();
      frm.delete();
      frm.push_back(tbl[i].len);
      frm.push_back(tbl[i].typ);
      if (tbl[i].len >= 1) frm.push_back(tbl[i].p0);
      if (tbl[i].len >= 2) frm.push_back(tbl[i].p1);
      finish_frame(tbl[i].corrupt);
      send_frm(0);
      repeat (4) tick();
      check($sformatf("tbl%0d_nrsp", i), tx_q.size() - t0, 1);
      if (tx_q.size() > t0) check($sformatf("tbl%0d_rsp", i), tx_q[t0], tbl[i].rsp);
      check($sformatf("tbl%0d_err", i), err_cnt - e0, tbl[i].err);
      check($sformatf("tbl%0d_step", i), step, tbl[i].st);
      check($sformatf("tbl%0d_range", i), range, tbl[i].rg);
      check($sformatf("tbl%0d_base", i), base_addr, tbl[i].ba);
    end
    m_step = 5; m_range = 'hF34; m_base = 'hFFE;

    // RAM write wrapping past the top of the address space.
    snap();
    frm = '{8'h06, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    finish_frame(1'b0);
    for (int i = 0; i < 8; i++) send_byte(frm[i]);
    check("wrap_last_we", bus.wr_enable, 1'b1);
    check("wrap_last_wa", bus.wr_addr, 12'h000);
    check("wrap_last_wd", bus.wr_data, 16'h5566);
    tick();
    check("wrap_hold", {bus.wr_enable, bus.wr_addr, bus.wr_data}, {1'b0, 12'h000, 16'h5566});
    send_byte(frm[8]);
    repeat (4) tick();
    model_check("wrap");

    // Trailing partial sample is discarded and NAKed.
    snap();
    frm = '{8'h03, 8'h05, 8'hAA, 8'hBB, 8'hCC};
    finish_frame(1'b0);
    send_frm(1);
    repeat (4) tick();
    model_check("partial");

    // Inter-byte timeout.
    snap();
    send_byte(8'h02); send_byte(8'h02);
    repeat (TO + 5) tick();
    check("to_err", err_cnt - e0, 1);
    check("to_nrsp", tx_q.size() - t0, 0);
    check("to_step", step, m_step);

    // Byte arriving on the expiry cycle keeps the frame alive.
    snap();
    frm = '{8'h02, 8'h02, 8'h00, 8'h01};
    finish_frame(1'b0);
    send_byte(frm[0]); send_byte(frm[1]);
    repeat (TO - 1) tick();
    for (int i = 2; i < 5; i++) send_byte(frm[i]);
    repeat (4) tick();
    model_check("to_edge");

    // sys_reset pulse width.
    snap();
    frm = '{8'h01, 8'h01, 8'h01};
    finish_frame(1'b0);
    for (int i = 0; i < 4; i++) send_byte(frm[i]);
    check("sysr_n1", sys_reset, 1'b1);
    tick();
    check("sysr_n2", sys_reset, 1'b0);
    repeat (3) tick();
    model_check("sysr");

    // Reset in the middle of a range frame.
    snap();
    send_byte(8'h02); send_byte(8'h03); send_byte(8'h0A);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_cfg", {step, range, base_addr}, {12'h001, 12'hFFF, 12'h000});
    repeat (4) tick();
    check("mid_rst_nrsp", tx_q.size() - t0, 0);
    check("mid_rst_err", err_cnt - e0, 0);
    m_step = 1; m_range = 'hFFF; m_base = 0;
    snap();
    frm = '{8'h02, 8'h03, 8'h04, 8'h56};
    finish_frame(1'b0);
    send_frm(0);
    repeat (4) tick();
    model_check("post_rst");

    // Random frames against the model.
    for (int f = 0; f < 60; f++) begin
      snap();
      k = $urandom_range(0, 6);
      typ = (k == 6) ? $urandom_range(6, 255) : k;
      case (typ)
        1:       len = 1;
        2, 3, 4: len = 2;
        5:       len = 2 * $urandom_range(0, 4);
        default: len = $urandom_range(0, 3);
      endcase
      if ($urandom_range(0, 3) == 0) len = $urandom_range(0, 7);
      frm.delete();
      frm.push_back(8'(len));
      frm.push_back(8'(typ));
      for (int i = 0; i < len; i++) frm.push_back(8'($urandom_range(0, 255)));
      finish_frame($urandom_range(0, 4) == 0);
      send_frm(3);
      repeat (4) tick();
      model_check($sformatf("rnd%0d", f));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/comm_frame_decoder.md
# comm_frame_decoder

Parametrised successor to the board's UART command interface. Consumes the received byte stream from the `uart` block and decodes length/type framed messages with a trailing checksum. Updates configuration registers atomically, streams sample words into the waveform RAM, and returns an ACK/NAK byte through the UART transmitter. Sits between `uart` and the RAM/generator core.

## Interface
- DATA_WIDTH, 16, RAM sample width; DATA_BYTES = ceil(DATA_WIDTH/8), sent MSB byte first
- ADDR_WIDTH, 12, RAM address width
- CFG_WIDTH, 12, width of step/range; CFG_BYTES = ceil(CFG_WIDTH/8)
- TIMEOUT_CYCLES, 1_000_000, inter-byte gap that aborts a frame; must be ≥ 2
- clk  in  1  system clock (single clock)
- reset  in  1  synchronous, active-high reset
- rx_valid  in  1  one-cycle strobe: rx_data holds a new byte
- rx_data  in  8  received byte
- tx_busy  in  1  UART transmitter busy
- tx_data  out  8  response byte (0x06 ACK, 0x15 NAK); reset 0
- send_data  out  1  one-cycle transmit strobe; reset 0
- wr_enable  out  1  one-cycle RAM write strobe; reset 0
- wr_addr  out  ADDR_WIDTH  RAM write address; reset 0
- wr_data  out  DATA_WIDTH  RAM write data; reset 0
- step  out  CFG_WIDTH  committed step; reset 1
- range  out  CFG_WIDTH  committed range; reset all ones
- base_addr  out  ADDR_WIDTH  committed base write address; reset 0
- sys_reset  out  1  one-cycle system reset pulse; reset 0
- frame_err  out  1  one-cycle pulse on checksum/length/type/timeout error; reset 0

## Operation
- Frame: LEN, TYPE, LEN payload bytes, CHK. CHK = XOR of LEN, TYPE and all payload bytes.
- FSM states:
  - IDLE: a byte sets LEN → TYPE.
  - TYPE: a byte sets TYPE → PAYLOAD, or → CHECK if LEN == 0.
  - PAYLOAD: count bytes; after byte LEN → CHECK.
  - CHECK: a byte compares CHK and commits or rejects → IDLE.
- Types:
  - 0x01 sys reset: LEN must be 1; payload bit0 drives the sys_reset pulse at commit.
  - 0x02 step, 0x03 range, 0x04 base_addr: LEN must equal CFG_BYTES, or for 0x04 ceil(ADDR_WIDTH/8). Bytes shift MSB first into a shadow register; low bits are kept.
  - 0x05 RAM write: each DATA_BYTES group forms one sample, written at base_addr + sample index, modulo 2^ADDR_WIDTH.
  - 0x00 and unknown types: NAK.
- Config and sys_reset take effect only on a good CHK with a legal LEN. Otherwise, send NAK, pulse frame_err, and leave committed values untouched.
- RAM writes stream immediately, with no rollback on a bad CHK; the NAK reports the bad frame. If LEN is not a multiple of DATA_BYTES, the trailing partial sample is discarded and the frame gets a NAK.
- Response path: a one-byte pending register. send_data pulses when the register is pending and tx_busy is 0, then pending clears. A new response replaces an unsent pending one.
- Timeout: a gap counter runs outside IDLE. When it reaches TIMEOUT_CYCLES: → IDLE, frame_err pulse, no response, no commit.

## Timing
- CHK byte on cycle N: committed registers and the sys_reset/frame_err pulses are visible at N+1. Pending is set at N+1; send_data is earliest at N+2.
- Last byte of a sample on cycle N: wr_enable, wr_addr and wr_data are valid together at N+1.
- wr_addr and wr_data hold their value between strobes.
- rx_valid and timeout expiry in the same cycle: the byte wins and the counter clears.
- Pending set while send_data fires in the same cycle: the new byte stays pending.
- reset mid-frame: → IDLE, all outputs and committed registers return to their reset values, pending clears.

## Structure
- Package comm_pkg holds:
  - type codes 0x01–0x05
  - ACK/NAK codes
  - FSM state encoding
  - byte-count helper function
- Sub-module comm_tx_responder owns the pending register and the tx_busy/send_data handshake.
- The top level holds the rx FSM, the shadow registers, the sample assembler and the timeout counter.

## Test plan
- Frame 02 02 00 05 CHK=0x05 → step = 5 at N+1, tx_data 0x06, one send_data after tx_busy drops.
- Same frame with CHK=0x00 → step unchanged at 1, frame_err pulse, NAK 0x15.
- base_addr set to 0xFFE, then frame 06 05 11 22 33 44 55 66 with good CHK → writes 0x1122@0xFFE, 0x3344@0xFFF, 0x5566@0x000, then ACK.
- Send LEN and TYPE, then idle for TIMEOUT_CYCLES → state IDLE, frame_err pulse, no send_data; the next valid frame is accepted.
- Frame 01 01 01 CHK=0x01 → sys_reset high for exactly one cycle, ACK.
- reset asserted mid-payload of a 0x03 frame → range = 0xFFF, no response; the following frame decodes correctly.
